alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter SIZE, default 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 holds an operation.
REQ-005 req0_ready / req1_ready  output  1  block accepts that requester's operation this cycle.
REQ-006 req0_op / req1_op  input  4  operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 MULT; other codes unsupported.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  SIZE  operands.
REQ-008 rsp_valid  output  1  response held for consumer.
REQ-009 rsp_ready  input  1  consumer takes response.
REQ-010 rsp_id  output  1  index of requester owning the response.
REQ-011 rsp_lo / rsp_hi  output  SIZE  result low word / MULT high word (0 for other ops).
REQ-012 rsp_zero, rsp_overflow  output  1  result flags.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, MULT, DONE.
REQ-015 IDLE: at most one readyN high; with one valid it is granted; with both valid the one not granted last wins (round-robin pointer).
REQ-016 Acceptance = validN && readyN on a rising edge; operands, op and id latched; pointer updated; next state MULT if op is 1000, else EXEC.
REQ-017 readyN SHALL be low in every state except IDLE.
REQ-018 EXEC: one cycle; AND/OR/ADD/SUB computed through the shared ALU; registered into rsp_lo; next state DONE.
REQ-019 ADD/SUB: rsp_overflow = bit SIZE of unsigned a+b / a-b (carry/borrow-out); AND/OR/unsupported: rsp_overflow = 0.
REQ-020 Unsupported op: rsp_lo = 0, rsp_zero = 1, EXEC path, no error signalled.
REQ-021 MULT: unsigned shift-add, exactly SIZE iterations, one per cycle, using the ALU ADD for the partial sum plus its carry-out; {hi,lo} = a*b full 2*SIZE product.
REQ-022 MULT: rsp_overflow = (rsp_hi != 0); rsp_zero = (rsp_hi == 0 && rsp_lo == 0).
REQ-023 Non-MULT: rsp_zero = (rsp_lo == 0); rsp_hi = 0.
REQ-024 Latency: rsp_valid rises 2 edges after the acceptance edge (non-MULT), SIZE+2 edges (MULT).
REQ-025 DONE: rsp_valid high; rsp_id/lo/hi/zero/overflow stable until the edge with rsp_ready high, then state IDLE, rsp_valid low.
REQ-026 rsp_ready while rsp_valid low SHALL be ignored.
REQ-027 Next acceptance no earlier than the cycle after the DONE->IDLE edge; changes on req inputs outside IDLE have no effect.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, rsp_valid/busy/ready outputs 0, rsp_id/lo/hi/zero/overflow 0, iteration counter 0.
REQ-029 Reset pointer SHALL favour req0 on the first simultaneous request.
REQ-030 Reset mid-operation (EXEC, MULT, DONE) SHALL discard the operation; no response is ever produced for it.

Structure
REQ-031 Op encodings (AND, OR, ADD, SUB, MULT) and state encodings SHALL live in a shared package alu_defs, also used by the ALU.
REQ-032 Exactly one sub-module: the existing ALU, instantiated with SIZE passed through; the multiply iteration counter and partial-product registers live in alu_arbiter.

Verification (SIZE=32)
REQ-033 req0 ADD a=FFFFFFFF b=00000001 -> rsp_lo=0, zero=1, overflow=1, id=0, rsp_valid 2 edges after acceptance.
REQ-034 req0 and req1 valid same cycle after reset, each holds valid -> req0 served first, then req1; repeat -> req0 first again (alternation).
REQ-035 req1 MULT a=FFFFFFFF b=FFFFFFFF -> rsp_hi=FFFFFFFE, rsp_lo=00000001, overflow=1, zero=0, rsp_valid after 34 edges.
REQ-036 rsp_ready low for 5 cycles in DONE -> outputs stable, both ready low, busy=1; rsp_ready high -> IDLE next edge.
REQ-037 rst_n pulsed low during MULT iteration 10 -> all outputs 0 at once, no response afterwards; new SUB a=5 b=7 -> rsp_lo=FFFFFFFE, overflow=1.
REQ-038 op 1111 a=3 b=4 -> rsp_lo=0, zero=1, overflow=0, 2-edge latency.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared operation codes and controller state encoding for the arbitrated ALU.
package alu_defs;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_MULT = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MULT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_mult(input logic [3:0] op);
        return (op == OP_MULT);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester operation bus plus single response channel of the arbitrated ALU.
interface alu_arbiter_if #(parameter int SIZE = 32);

    logic            req0_valid;
    logic            req0_ready;
    logic [3:0]      req0_op;
    logic [SIZE-1:0] req0_a;
    logic [SIZE-1:0] req0_b;
    logic            req1_valid;
    logic            req1_ready;
    logic [3:0]      req1_op;
    logic [SIZE-1:0] req1_a;
    logic [SIZE-1:0] req1_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [SIZE-1:0] rsp_lo;
    logic [SIZE-1:0] rsp_hi;
    logic            rsp_zero;
    logic            rsp_overflow;
    logic            busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_zero, rsp_overflow, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_zero, rsp_overflow, busy
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: AND/OR/ADD/SUB with carry/borrow-out; unsupported codes give zero.
module alu_arbiter_alu
    import alu_defs::*;
#(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] a_i,
    input  logic [SIZE-1:0] b_i,
    input  logic [3:0]      op_i,
    output logic [SIZE-1:0] y_o,
    output logic            cout_o
);

    logic [SIZE:0] sum_s;

    // Operation decode; the extra MSB of sum_s is the carry or borrow-out.
    always_comb begin
        sum_s  = {(SIZE+1){1'b0}};
        y_o    = {SIZE{1'b0}};
        cout_o = 1'b0;
        case (op_i)
            OP_AND: y_o = a_i & b_i;
            OP_OR:  y_o = a_i | b_i;
            OP_ADD: begin
                sum_s  = {1'b0, a_i} + {1'b0, b_i};
                y_o    = sum_s[SIZE-1:0];
                cout_o = sum_s[SIZE];
            end
            OP_SUB: begin
                sum_s  = {1'b0, a_i} - {1'b0, b_i};
                y_o    = sum_s[SIZE-1:0];
                cout_o = sum_s[SIZE];
            end
            default: y_o = {SIZE{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a shared ALU; MULT runs as SIZE shift-add steps
// through the ALU adder, and the result is held until the consumer takes it.
module alu_arbiter
    import alu_defs::*;
#(
    parameter int SIZE = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    localparam int             CW       = $clog2(SIZE + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SIZE);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_e          state_q;
    logic            last_q;
    logic            id_q;
    logic [3:0]      op_q;
    logic [SIZE-1:0] a_q, b_q, acc_q, mlo_q;
    logic [CW-1:0]   cnt_q;
    logic            rsp_valid_q, rsp_id_q, rsp_zero_q, rsp_ovf_q;
    logic [SIZE-1:0] rsp_lo_q, rsp_hi_q;

    logic            grant0_s, grant1_s;
    logic [3:0]      sel_op_s;
    logic [SIZE-1:0] sel_a_s, sel_b_s;
    logic [SIZE-1:0] alu_a_s, alu_b_s, alu_y_s;
    logic [3:0]      alu_op_s;
    logic            alu_cout_s;

    // Grant in IDLE only; last_q=1 means req1 won last, so req0 wins the next tie.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst_n && (state_q == ST_IDLE)) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0_s = last_q;
                grant1_s = ~last_q;
            end else begin
                grant0_s = bus.req0_valid;
                grant1_s = bus.req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
        sel_op_s = grant1_s ? bus.req1_op : bus.req0_op;
        sel_a_s  = grant1_s ? bus.req1_a  : bus.req0_a;
        sel_b_s  = grant1_s ? bus.req1_b  : bus.req0_b;
    end

    // During MULT the ALU adds the multiplicand into the running high word.
    always_comb begin
        if (state_q == ST_MULT) begin
            alu_a_s  = acc_q;
            alu_b_s  = mlo_q[0] ? a_q : {SIZE{1'b0}};
            alu_op_s = OP_ADD;
        end else begin
            alu_a_s  = a_q;
            alu_b_s  = b_q;
            alu_op_s = op_q;
        end
    end

    alu_arbiter_alu #(.SIZE(SIZE)) u_alu (
        .a_i    (alu_a_s),
        .b_i    (alu_b_s),
        .op_i   (alu_op_s),
        .y_o    (alu_y_s),
        .cout_o (alu_cout_s)
    );

    // Controller FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            op_q        <= 4'b0000;
            a_q         <= {SIZE{1'b0}};
            b_q         <= {SIZE{1'b0}};
            acc_q       <= {SIZE{1'b0}};
            mlo_q       <= {SIZE{1'b0}};
            cnt_q       <= {CW{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_lo_q    <= {SIZE{1'b0}};
            rsp_hi_q    <= {SIZE{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant0_s || grant1_s) begin
                        id_q    <= grant1_s;
                        last_q  <= grant1_s;
                        op_q    <= sel_op_s;
                        a_q     <= sel_a_s;
                        b_q     <= sel_b_s;
                        acc_q   <= {SIZE{1'b0}};
                        mlo_q   <= sel_b_s;
                        cnt_q   <= {CW{1'b0}};
                        state_q <= is_mult(sel_op_s) ? ST_MULT : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_lo_q   <= alu_y_s;
                    rsp_hi_q   <= {SIZE{1'b0}};
                    rsp_zero_q <= (alu_y_s == {SIZE{1'b0}});
                    rsp_ovf_q  <= alu_cout_s;
                    rsp_id_q   <= id_q;
                    state_q    <= ST_DONE;
                end
                ST_MULT: begin
                    if (cnt_q == CNT_LAST) begin
                        rsp_lo_q   <= mlo_q;
                        rsp_hi_q   <= acc_q;
                        rsp_zero_q <= (acc_q == {SIZE{1'b0}}) && (mlo_q == {SIZE{1'b0}});
                        rsp_ovf_q  <= (acc_q != {SIZE{1'b0}});
                        rsp_id_q   <= id_q;
                        state_q    <= ST_DONE;
                    end else begin
                        // {carry, sum, multiplier} shifts right one place per step
                        acc_q <= {alu_cout_s, alu_y_s[SIZE-1:1]};
                        mlo_q <= {alu_y_s[0], mlo_q[SIZE-1:1]};
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req0_ready   = grant0_s;
    assign bus.req1_ready   = grant1_s;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_lo       = rsp_lo_q;
    assign bus.rsp_hi       = rsp_hi_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_overflow = rsp_ovf_q;
    assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized transactions checked against an arithmetic reference model.
module tb_alu_arbiter;

    localparam int SIZE = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.SIZE(SIZE)) bus();
    alu_arbiter #(.SIZE(SIZE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   checks = 0;
    int   failures = 0;
    logic last_m;   // 1: requester 1 was served last
    logic [3:0] ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1000, 4'b1111, 4'b0101};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi,
                         output logic z, output logic ov, output int lat);
        logic [32:0] s;
        logic [63:0] p;
        hi = 32'h0; ov = 1'b0; lat = 2; lo = 32'h0;
        case (op)
            4'b0000: lo = a & b;
            4'b0001: lo = a | b;
            4'b0010: begin s = {1'b0, a} + {1'b0, b}; lo = s[31:0]; ov = s[32]; end
            4'b0110: begin s = {1'b0, a} - {1'b0, b}; lo = s[31:0]; ov = s[32]; end
            4'b1000: begin
                p = {32'h0, a} * {32'h0, b};
                lo = p[31:0]; hi = p[63:32]; ov = (hi != 32'h0); lat = SIZE + 2;
            end
            default: lo = 32'h0;
        endcase
        z = (hi == 32'h0) && (lo == 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {57'h0, bus.rsp_valid, bus.req0_ready, bus.req1_ready, bus.busy,
                              bus.rsp_id, bus.rsp_zero, bus.rsp_overflow}, 64'h0);
        check({tag, "_data"}, {bus.rsp_hi, bus.rsp_lo}, 64'h0);
    endtask

    // Starts and ends at a falling edge with the DUT idle.
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                           input int hold);
        logic win, ez, eov;
        logic [31:0] elo, ehi;
        int elat, lat;
        win = (v0 && v1) ? ~last_m : v1;
        last_m = win;
        if (win) model(op1, a1, b1, elo, ehi, ez, eov, elat);
        else     model(op0, a0, b0, elo, ehi, ez, eov, elat);
        bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
        #1;
        check("grant", {62'h0, bus.req0_ready, bus.req1_ready}, {62'h0, ~win, win});
        @(posedge clk);
        @(negedge clk);
        check("busy_after_accept", {61'h0, bus.req0_ready, bus.req1_ready, bus.busy}, 64'h1);
        bus.req0_op = ops[$urandom_range(0, 6)]; bus.req0_a = $urandom; bus.req0_b = $urandom;
        bus.req1_op = ops[$urandom_range(0, 6)]; bus.req1_a = $urandom; bus.req1_b = $urandom;
        lat = 0;
        while (!bus.rsp_valid && lat < 60) begin
            bus.rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        bus.rsp_ready = 1'b0;
        check("latency", 64'(lat), 64'(elat));
        check("rsp_ctl", {58'h0, bus.rsp_id, bus.rsp_zero, bus.rsp_overflow, bus.req0_ready,
                          bus.req1_ready, bus.busy}, {58'h0, win, ez, eov, 3'b001});
        check("rsp_data", {bus.rsp_hi, bus.rsp_lo}, {ehi, elo});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_ctl", {57'h0, bus.rsp_valid, bus.req0_ready, bus.req1_ready, bus.busy,
                               bus.rsp_id, bus.rsp_zero, bus.rsp_overflow},
                  {57'h0, 4'b1001, win, ez, eov});
            check("hold_data", {bus.rsp_hi, bus.rsp_lo}, {ehi, elo});
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("release", {62'h0, bus.rsp_valid, bus.busy}, 64'h0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        logic [1:0] v;
        logic [31:0] ra [4];
        bus.rsp_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 4'b0010; bus.req0_a = 32'h1; bus.req0_b = 32'h2;
        bus.req1_valid = 1'b1; bus.req1_op = 4'b0010; bus.req1_a = 32'h3; bus.req1_b = 32'h4;
        last_m = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Tie-breaking alternates starting with requester 0
        run_txn(1'b1, 1'b1, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 4'b0001, 32'h1, 32'h2, 0);
        run_txn(1'b1, 1'b1, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 4'b0001, 32'h1, 32'h2, 1);
        run_txn(1'b1, 1'b1, 4'b0010, 32'h7, 32'h8, 4'b0110, 32'h9, 32'h3, 0);
        run_txn(1'b1, 1'b1, 4'b0010, 32'h7, 32'h8, 4'b0110, 32'h9, 32'h3, 0);

        run_txn(1'b1, 1'b0, 4'b0010, 32'hFFFF_FFFF, 32'h1, 4'b0000, 32'h0, 32'h0, 0);
        run_txn(1'b0, 1'b1, 4'b0000, 32'h0, 32'h0, 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        run_txn(1'b1, 1'b0, 4'b1111, 32'h3, 32'h4, 4'b0000, 32'h0, 32'h0, 0);
        run_txn(1'b1, 1'b0, 4'b1000, 32'h0, 32'h1234_5678, 4'b0000, 32'h0, 32'h0, 0);

        // Reset in the middle of a multiply discards it
        bus.req1_valid = 1'b1; bus.req1_op = 4'b1000;
        bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        #1;
        check_all_zero("reset_mid_mult");
        bus.req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_m = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid | bus.busy;
        end
        check("no_rsp_after_reset", {63'h0, seen}, 64'h0);
        run_txn(1'b1, 1'b0, 4'b0110, 32'h5, 32'h7, 4'b0000, 32'h0, 32'h0, 0);

        for (int n = 0; n < 24; n++) begin
            v = 2'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0: ra[k] = 32'h0;
                    1: ra[k] = 32'hFFFF_FFFF;
                    default: ra[k] = $urandom;
                endcase
            end
            run_txn(v[0], v[1], ops[$urandom_range(0, 6)], ra[0], ra[1],
                    ops[$urandom_range(0, 6)], ra[2], ra[3], $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
